lfu_buf_ctrl: RTL

- Controller for a 4-entry buffer pool with least-frequently-used replacement.
- Accepts tag lookup requests from one requester and keeps per-entry valid, tag and 2-bit use counters.
- Hits return the matching buffer number. Misses allocate a buffer: a free entry if one exists, otherwise the LFU victim, which is evicted through a handshake before the fill.
- Sits between the request front-end and the buffer storage/writeback path.

---
 rtl/lfu_buf_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/lfu_buf_ctrl.sv
// lfu_buf_ctrl: tag lookup / allocation controller for a 4-entry buffer pool
// with least-frequently-used replacement.
// Latency from request accept: hit -> response 2 cycles; free miss -> fill 2, response 3;
// eviction miss -> evict request 2 cycles, fill 1 cycle after ack, response 2 after ack.
// Backpressure: one transaction in flight; req_ready low outside IDLE; evict and response
// are held until evict_ack / rsp_ready.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready/req_tag   lookup request handshake
//   rsp_valid/rsp_ready           response handshake; rsp_buf, rsp_hit describe the result
//   evict_valid/evict_ack         victim writeback handshake; evict_buf, evict_tag
//   fill_valid                    one-cycle pulse: fill_buf now holds fill_tag
//   flush                         invalidate all entries (honoured in IDLE only)

module lfu_buf_ctrl #(
    parameter int TAG_W   = 8,
    parameter int CNT_MAX = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [TAG_W-1:0] req_tag,
    output logic             req_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_buf,
    output logic             rsp_hit,
    output logic             evict_valid,
    output logic [1:0]       evict_buf,
    output logic [TAG_W-1:0] evict_tag,
    input  logic             evict_ack,
    output logic             fill_valid,
    output logic [1:0]       fill_buf,
    output logic [TAG_W-1:0] fill_tag,
    input  logic             flush
);

    localparam logic [1:0] CMAX = 2'(CNT_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_EVICT,
        S_FILL,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              valid_q, valid_d;
    logic [3:0][TAG_W-1:0]   tag_q, tag_d;
    logic [3:0][1:0]         cnt_q, cnt_d;
    logic [TAG_W-1:0]        cap_tag_q, cap_tag_d;
    logic [1:0]              victim_q, victim_d;
    logic [1:0]              rsp_buf_q, rsp_buf_d;
    logic                    rsp_hit_q, rsp_hit_d;

    // Lookup helpers, evaluated against the captured tag.
    logic       hit;
    logic [1:0] hit_idx;
    logic       free_any;
    logic [1:0] free_idx;
    logic [1:0] min_idx;
    logic [1:0] min_cnt;
    logic       all_max;

    always_comb begin
        hit      = 1'b0;
        hit_idx  = 2'd0;
        free_any = 1'b0;
        free_idx = 2'd0;
        min_idx  = 2'd0;
        min_cnt  = cnt_q[0];
        all_max  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (valid_q[i] && (tag_q[i] == cap_tag_q) && !hit) begin
                hit     = 1'b1;
                hit_idx = 2'(i);
            end
            if (!valid_q[i] && !free_any) begin
                free_any = 1'b1;
                free_idx = 2'(i);
            end
            if (valid_q[i] && (cnt_q[i] != CMAX)) begin
                all_max = 1'b0;
            end
        end
        // Strict less-than keeps the lowest index on ties.
        for (int i = 1; i < 4; i++) begin
            if (cnt_q[i] < min_cnt) begin
                min_cnt = cnt_q[i];
                min_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        tag_d     = tag_q;
        cnt_d     = cnt_q;
        cap_tag_d = cap_tag_q;
        victim_d  = victim_q;
        rsp_buf_d = rsp_buf_q;
        rsp_hit_d = rsp_hit_q;

        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    valid_d = '0;
                    cnt_d   = '0;
                end else if (req_valid) begin
                    cap_tag_d = req_tag;
                    state_d   = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    rsp_buf_d = hit_idx;
                    rsp_hit_d = 1'b1;
                    state_d   = S_RESP;
                    if (cnt_q[hit_idx] < CMAX) begin
                        cnt_d[hit_idx] = cnt_q[hit_idx] + 2'd1;
                    end else if (all_max) begin
                        // Aging: every valid counter is saturated, so
                        // restart them all at 1 to keep LFU information.
                        for (int i = 0; i < 4; i++) begin
                            if (valid_q[i]) begin
                                cnt_d[i] = 2'd1;
                            end
                        end
                    end
                end else if (free_any) begin
                    victim_d = free_idx;
                    state_d  = S_FILL;
                end else begin
                    victim_d = min_idx;
                    state_d  = S_EVICT;
                end
            end
            S_EVICT: begin
                if (evict_ack) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                tag_d[victim_q]   = cap_tag_q;
                valid_d[victim_q] = 1'b1;
                cnt_d[victim_q]   = 2'd1;
                rsp_buf_d         = victim_q;
                rsp_hit_d         = 1'b0;
                state_d           = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            valid_q   <= '0;
            tag_q     <= '0;
            cnt_q     <= '0;
            cap_tag_q <= '0;
            victim_q  <= 2'd0;
            rsp_buf_q <= 2'd0;
            rsp_hit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            cnt_q     <= cnt_d;
            cap_tag_q <= cap_tag_d;
            victim_q  <= victim_d;
            rsp_buf_q <= rsp_buf_d;
            rsp_hit_q <= rsp_hit_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE) && !flush;
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_buf     = rsp_buf_q;
    assign rsp_hit     = rsp_hit_q;
    assign evict_valid = (state_q == S_EVICT);
    assign evict_buf   = victim_q;
    assign evict_tag   = tag_q[victim_q];
    assign fill_valid  = (state_q == S_FILL);
    assign fill_buf    = victim_q;
    assign fill_tag    = cap_tag_q;

endmodule
